// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bundle: memctrl instruction port, decode queue head
// and the branch/commit redirect.
interface if_fetch_queue_if;
  logic        if_read_or_not;
  logic [31:0] intru_addr;
  logic        if_load_done;
  logic [31:0] mem_ctrl_instru_to_if;
  logic        iq_valid;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic        dec_ready;
  logic        jump_flag;
  logic [31:0] jump_pc;

  modport master (
    output if_read_or_not,
    output intru_addr,
    output iq_valid,
    output iq_instr,
    output iq_pc,
    input  if_load_done,
    input  mem_ctrl_instru_to_if,
    input  dec_ready,
    input  jump_flag,
    input  jump_pc
  );

  modport slave (
    input  if_read_or_not,
    input  intru_addr,
    input  iq_valid,
    input  iq_instr,
    input  iq_pc,
    output if_load_done,
    output mem_ctrl_instru_to_if,
    output dec_ready,
    output jump_flag,
    output jump_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: one outstanding memctrl request, results
// captured with their PC into a small queue read by decode.
module if_fetch_queue #(
  parameter int          IQ_DEPTH   = 8,
  parameter int          IQ_PTR_LEN = 3,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  if_fetch_queue_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  typedef logic [IQ_PTR_LEN-1:0] ptr_t;
  typedef logic [IQ_PTR_LEN:0]   cnt_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] addr, addr_n;
  logic        req, req_n;
  ptr_t        head, tail;
  cnt_t        count;
  logic        push, pop, flush, full;

  logic [31:0] instr_q [IQ_DEPTH];
  logic [31:0] pc_q    [IQ_DEPTH];

  assign full               = (count == cnt_t'(IQ_DEPTH));
  assign bus.iq_valid       = (count != '0);
  assign bus.iq_instr       = instr_q[head];
  assign bus.iq_pc          = pc_q[head];
  assign bus.if_read_or_not = req;
  assign bus.intru_addr     = addr;

  // Redirect wins over any reply or pop arriving in the same cycle.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = addr;
    req_n   = req;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    if (bus.jump_flag) begin
      flush   = 1'b1;
      pc_n    = bus.jump_pc;
      req_n   = 1'b0;
      state_n = GAP;
    end else begin
      pop = (count != '0) && bus.dec_ready;
      unique case (state)
        IDLE: begin
          if (!full) begin
            state_n = REQ;
            req_n   = 1'b1;
            addr_n  = pc;
          end
        end
        REQ: begin
          if (bus.if_load_done) begin
            push    = 1'b1;
            pc_n    = pc + 32'd4;
            req_n   = 1'b0;
            state_n = GAP;
          end
        end
        GAP:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      pc    <= RESET_PC;
      addr  <= '0;
      req   <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      state <= state_n;
      pc    <= pc_n;
      addr  <= addr_n;
      req   <= req_n;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + ptr_t'(1);
        if (pop)  head <= head + ptr_t'(1);
        unique case ({push, pop})
          2'b10:   count <= count + cnt_t'(1);
          2'b01:   count <= count - cnt_t'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage needs no reset; count gates visibility.
  always_ff @(posedge clk_in) begin
    if (rdy_in && push) begin
      instr_q[tail] <= bus.mem_ctrl_instru_to_if;
      pc_q[tail]    <= pc;
    end
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction fetch stage that sits directly upstream of the memory controller's instruction port. It drives fetch requests from the PC register and captures each returned word with its PC into an instruction queue. It presents the head entry to decode and supports a redirect from the branch/commit logic that flushes all pending state.

Parameters:
IQ_DEPTH, 8, number of instruction queue entries (power of two)
IQ_PTR_LEN, 3, log2(IQ_DEPTH)
RESET_PC, 32'h00000000, PC loaded at reset

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_in  input  1  reset, asynchronous, active-low (0 = reset)
rdy_in  input  1  global ready; 0 freezes all state
if_read_or_not  output  1  fetch request to memctrl, registered
intru_addr  output  32  fetch address to memctrl, registered
if_load_done  input  1  one-cycle pulse from memctrl, word valid
mem_ctrl_instru_to_if  input  32  fetched word, valid when if_load_done=1
iq_valid  output  1  queue non-empty
iq_instr  output  32  head-entry instruction
iq_pc  output  32  head-entry PC
dec_ready  input  1  decode pops the head when iq_valid=1 and dec_ready=1
jump_flag  input  1  redirect strobe
jump_pc  input  32  redirect target, valid when jump_flag=1

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC, state=IDLE, head/tail/count=0, if_read_or_not=0, intru_addr=0. iq_valid=0. Reset mid-fetch abandons the request; no handshake completion is required.
- rdy_in=0: no register changes, including push, pop and redirect. Inputs seen during that cycle are lost.
- iq_valid = (count!=0). iq_instr/iq_pc come combinationally from the head entry.
- FSM states: IDLE, REQ, GAP.
- IDLE: if count<IQ_DEPTH, go to REQ next cycle with if_read_or_not<=1 and intru_addr<=pc. Otherwise stay in IDLE.
- REQ: hold if_read_or_not=1 and intru_addr stable until if_load_done=1. Memctrl may stall arbitrarily, e.g. while serving a data access.
- On if_load_done in REQ:
  - push {mem_ctrl_instru_to_if, pc} at tail;
  - pc<=pc+4 (32-bit wrap);
  - if_read_or_not<=0;
  - go to GAP.
- GAP: exactly one cycle with request low. Any if_load_done here is ignored; it is the duplicate cache-hit reply to the address just served. Then go to IDLE.
- A request is only launched when not full. At most one request is outstanding, so a push can never overflow.
- Pop when iq_valid && dec_ready: head<=head+1 (wraps mod IQ_DEPTH).
- Simultaneous push and pop: count unchanged, both pointers advance. Pop from an empty queue is ignored.
- Redirect (jump_flag=1) has priority over everything in the same cycle:
  - pc<=jump_pc;
  - head=tail=count=0;
  - if_read_or_not<=0;
  - state<=GAP.
  - A same-cycle if_load_done is discarded, and a same-cycle pop has no effect.
  - The next request uses jump_pc.
- Latency: the first request is issued 1 cycle after reset release. A pushed word is visible at the head 1 cycle after the if_load_done cycle.
- No misaligned-PC checks; jump_pc is used as given.

Test Plan:
- Reset release with RESET_PC=0 and memctrl model returning done 6 cycles after request, words 0x11,0x22,0x33 → intru_addr 0,4,8 in order. Queue delivers (0x11,pc0), (0x22,pc4), (0x33,pc8). Exactly one GAP cycle with request low between fetches.
- dec_ready=0, instant-hit model → count reaches 8 and if_read_or_not stays 0 in IDLE. Assert dec_ready for 1 cycle → one pop, and exactly one new fetch at pc 0x20.
- Memctrl model replays if_load_done in the cycle after each done (cache-hit duplicate) → no duplicate entries; queue PCs are strictly +4.
- jump_flag=1 with jump_pc=0x1000 during REQ at pc 0x8, with if_load_done in the same cycle → iq_valid=0 next cycle, the 0x8 word is never queued, and the next intru_addr is 0x1000.
- Push and pop in the same cycle at count=3 → count stays 3 and head PC advances by 4. Also: pc 0xFFFFFFFC plus one fetch → pc wraps to 0.
- rst_in driven low mid-REQ between clock edges → outputs go to 0 immediately, without waiting for a clock edge. rdy_in=0 for 5 cycles during REQ with done asserted → no push occurs and state is unchanged.
